// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder
//
// Address decoder and slave-side router for the serial system bus. It sits
// between the arbiter's granted-master path and the slave ports. While the
// arbiter holds a grant (bus_busy), the block:
//   1. shifts in a DEV_W-bit device ID, MSB first, from m_wr_bus. A bit is
//      taken on each edge where bus_busy and m_master_valid are both high.
//   2. decodes the ID to a registered one-hot s_sel. It pulses dec_ack for a
//      valid ID and dec_err for an out-of-range ID.
//   3. forwards the master's write line and handshakes to the selected
//      slave, and muxes that slave's return lines back, until bus_busy falls.
//
// Optional feature: define ADDR_DEC_TIMEOUT_EN to build an idle watchdog for
// the connected phase. After TIMEOUT consecutive cycles with no master or
// selected-slave valid, the block pulses dec_err and drops the connection.
// Without the macro the connection lasts until bus_busy falls, and no
// counter is built.
//
// Parameters
//   NUM_SLAVES  number of slave ports; valid device IDs are 0..NUM_SLAVES-1
//   DEV_W       device-ID width in bits (2**DEV_W >= NUM_SLAVES)
//   TIMEOUT     idle-cycle limit in CONNECT (ADDR_DEC_TIMEOUT_EN only)
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   bus_busy         arbiter grant is held
//   m_wr_bus         granted master's serial write line
//   m_master_valid   granted master's valid, qualifies m_wr_bus
//   m_master_ready   granted master can accept read data
//   m_rd_bus         selected slave's read line, back to the master
//   m_slave_valid    selected slave's valid, back to the master
//   m_slave_ready    selected slave's ready, back to the master
//   dec_ack          one-cycle pulse: ID valid, slave connected
//   dec_err          one-cycle pulse: bad ID or idle timeout
//   s_sel            registered one-hot slave select
//   s_wr_bus         m_wr_bus broadcast to every slave
//   s_master_valid   m_master_valid gated per slave by s_sel
//   s_master_ready   m_master_ready gated per slave by s_sel
//   s_rd_bus, s_slave_valid, s_slave_ready   per-slave return lines
//
// Handshake semantics: a transfer on the forwarded path happens on a rising
// edge where the sender's valid and the receiver's ready are both high. This
// block does not qualify or register those handshakes. It only gates them
// with s_sel, so a slave sees valid/ready only while it is selected.
//
// The FSM state is held in the enum variable 'state' so that checkers can
// bind to it.

module bus_addr_decoder #(
  parameter int NUM_SLAVES = 3,
  parameter int DEV_W      = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_busy,
  input  logic                  m_wr_bus,
  input  logic                  m_master_valid,
  input  logic                  m_master_ready,
  output logic                  m_rd_bus,
  output logic                  m_slave_valid,
  output logic                  m_slave_ready,
  output logic                  dec_ack,
  output logic                  dec_err,
  output logic [NUM_SLAVES-1:0] s_sel,
  output logic                  s_wr_bus,
  output logic [NUM_SLAVES-1:0] s_master_valid,
  output logic [NUM_SLAVES-1:0] s_master_ready,
  input  logic [NUM_SLAVES-1:0] s_rd_bus,
  input  logic [NUM_SLAVES-1:0] s_slave_valid,
  input  logic [NUM_SLAVES-1:0] s_slave_ready
);

  // Bit counter: holds the number of ID bits received so far (0..DEV_W).
  localparam int CNT_W = $clog2(DEV_W + 1);
  // Count value just before the final ID bit arrives.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEV_W - 1);
  // NUM_SLAVES sized one bit wider than the ID, used for the range check.
  localparam logic [DEV_W:0] NUM_SLAVES_W = (DEV_W + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DECODE,
    ST_CONNECT,
    ST_WAIT_REL
  } state_t;

  state_t             state;
  logic [DEV_W-1:0]   shift_q;
  logic [CNT_W-1:0]   bit_cnt;

  logic [DEV_W:0]          shift_ext;
  logic [DEV_W-1:0]        shift_next;
  logic                    id_ok;
  logic [NUM_SLAVES-1:0]   sel_dec;
  logic                    tmo_hit;

  // Shift left, new bit enters at the LSB. This gives MSB-first assembly.
  assign shift_ext  = {shift_q, m_wr_bus};
  assign shift_next = shift_ext[DEV_W-1:0];

  assign id_ok = ({1'b0, shift_q} < NUM_SLAVES_W);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (shift_q == DEV_W'(i)) sel_dec[i] = 1'b1;
    end
  end

`ifdef ADDR_DEC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // tmo_hit fires on the idle cycle that brings the count up to TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             activity;

  // Activity is any master valid, or a valid from the connected slave.
  assign activity = m_master_valid | (|(s_slave_valid & s_sel));
  assign tmo_hit  = (state == ST_CONNECT) && !activity && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!bus_busy || state != ST_CONNECT || activity || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main FSM. dec_ack and dec_err default low every cycle, so each is a
  // single-cycle pulse. A release (bus_busy low) takes priority in every
  // state, which also makes a release beat a same-edge timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_sel   <= '0;
      dec_ack <= 1'b0;
      dec_err <= 1'b0;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      dec_ack <= 1'b0;
      dec_err <= 1'b0;
      if (!bus_busy) begin
        // Release or abort: any partial ID is dropped without a pulse.
        state   <= ST_IDLE;
        s_sel   <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (m_master_valid) begin
              // First ID bit: start fresh, not from stale shift contents.
              shift_q <= DEV_W'(m_wr_bus);
              bit_cnt <= CNT_W'(1);
              state   <= (DEV_W == 1) ? ST_DECODE : ST_ADDR;
            end
          end

          ST_ADDR: begin
            // A cycle with m_master_valid low stalls and holds the state.
            if (m_master_valid) begin
              shift_q <= shift_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_CNT) state <= ST_DECODE;
            end
          end

          ST_DECODE: begin
            bit_cnt <= '0;
            if (id_ok) begin
              s_sel   <= sel_dec;
              dec_ack <= 1'b1;
              state   <= ST_CONNECT;
            end else begin
              dec_err <= 1'b1;
              state   <= ST_WAIT_REL;
            end
          end

          ST_CONNECT: begin
            if (tmo_hit) begin
              dec_err <= 1'b1;
              s_sel   <= '0;
              state   <= ST_WAIT_REL;
            end
          end

          ST_WAIT_REL: begin
            // Hold here with nothing selected until the arbiter releases.
            s_sel <= '0;
          end

          default: begin
            state <= ST_IDLE;
            s_sel <= '0;
          end
        endcase
      end
    end
  end

  // Forward path: the write line goes to every slave. The handshakes are
  // gated so that only the selected slave sees them.
  assign s_wr_bus       = m_wr_bus;
  assign s_master_valid = {NUM_SLAVES{m_master_valid}} & s_sel;
  assign s_master_ready = {NUM_SLAVES{m_master_ready}} & s_sel;

  // Return path: an AND-OR mux driven by the registered one-hot select. All
  // outputs are 0 when nothing is selected.
  assign m_rd_bus      = |(s_rd_bus      & s_sel);
  assign m_slave_valid = |(s_slave_valid & s_sel);
  assign m_slave_ready = |(s_slave_ready & s_sel);

endmodule

// File: tb/tb_bus_addr_decoder.sv
module tb_bus_addr_decoder;

  localparam int NS  = 3;
  localparam int DW  = 2;
  localparam int TMO = 4;
  localparam int W   = 5;   // expected word: {dec_ack, dec_err, s_sel[2:0]}

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          bus_busy;
  logic          m_wr_bus;
  logic          m_master_valid;
  logic          m_master_ready;
  logic          m_rd_bus;
  logic          m_slave_valid;
  logic          m_slave_ready;
  logic          dec_ack;
  logic          dec_err;
  logic [NS-1:0] s_sel;
  logic          s_wr_bus;
  logic [NS-1:0] s_master_valid;
  logic [NS-1:0] s_master_ready;
  logic [NS-1:0] s_rd_bus;
  logic [NS-1:0] s_slave_valid;
  logic [NS-1:0] s_slave_ready;

  always #5 clk = ~clk;

  bus_addr_decoder #(
    .NUM_SLAVES(NS),
    .DEV_W     (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_busy      (bus_busy),
    .m_wr_bus      (m_wr_bus),
    .m_master_valid(m_master_valid),
    .m_master_ready(m_master_ready),
    .m_rd_bus      (m_rd_bus),
    .m_slave_valid (m_slave_valid),
    .m_slave_ready (m_slave_ready),
    .dec_ack       (dec_ack),
    .dec_err       (dec_err),
    .s_sel         (s_sel),
    .s_wr_bus      (s_wr_bus),
    .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready),
    .s_rd_bus      (s_rd_bus),
    .s_slave_valid (s_slave_valid),
    .s_slave_ready (s_slave_ready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives the ID MSB first, one bit per cycle. It returns at the negedge
  // after the edge that sampled the last bit, with valid low.
  task automatic send_id(input logic [DW-1:0] id);
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge clk);
      bus_busy       = 1'b1;
      m_master_valid = 1'b1;
      m_wr_bus       = id[i];
    end
    @(negedge clk);
    m_master_valid = 1'b0;
    m_wr_bus       = 1'b0;
  endtask

  // Called in the DECODE cycle. It checks that no pulse is high yet, then
  // pops the scoreboard and compares one edge later.
  task automatic check_decode(input string tag);
    logic [W-1:0] e;
    check({tag, "_decode_quiet"}, {dec_ack, dec_err}, 2'b00);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb_empty: actual=empty required=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pulse"}, {dec_ack, dec_err, s_sel}, e);
    end
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus_busy       = 1'b0;
    m_master_valid = 1'b0;
    m_master_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] id;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pat;
    logic [2:0] sv;

    vecs[0] = '{id: 2'd0, exp: 5'b10_001};
    vecs[1] = '{id: 2'd1, exp: 5'b10_010};
    vecs[2] = '{id: 2'd2, exp: 5'b10_100};
    vecs[3] = '{id: 2'd3, exp: 5'b01_000};

    // Reset with every input high. All outputs must be masked to 0.
    rst            = 1'b1;
    bus_busy       = 1'b0;
    m_wr_bus       = 1'b1;
    m_master_valid = 1'b1;
    m_master_ready = 1'b1;
    s_rd_bus       = 3'b111;
    s_slave_valid  = 3'b111;
    s_slave_ready  = 3'b111;
    #3;
    check("reset_outs", {s_sel, dec_ack, dec_err, m_rd_bus, m_slave_valid, m_slave_ready,
                         s_master_valid, s_master_ready}, 0);
    check("wr_broadcast_1", s_wr_bus, 1'b1);
    m_wr_bus = 1'b0;
    #1;
    check("wr_broadcast_0", s_wr_bus, 1'b0);
    repeat (2) @(negedge clk);
    rst            = 1'b0;
    m_master_valid = 1'b0;
    m_master_ready = 1'b0;
    s_rd_bus       = '0;
    s_slave_valid  = '0;
    s_slave_ready  = '0;
    @(negedge clk);
    check("idle_after_reset", {s_sel, dec_ack, dec_err}, 0);

    // Table-driven: every ID, with a forward/return check and a release.
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp);
      send_id(vecs[v].id);
      check_decode($sformatf("vec%0d", v));
      @(negedge clk);
      check($sformatf("vec%0d_hold", v), {dec_ack, dec_err, s_sel}, {2'b00, vecs[v].exp[2:0]});
      m_master_valid = 1'b1;
      m_master_ready = 1'b1;
      s_slave_valid  = 3'b111;
      s_slave_ready  = 3'b111;
      #1;
      check($sformatf("vec%0d_fwd", v), {s_master_valid, s_master_ready},
            {vecs[v].exp[2:0], vecs[v].exp[2:0]});
      check($sformatf("vec%0d_ret", v), {m_slave_valid, m_slave_ready},
            {2{vecs[v].exp[4]}});
      release_bus();
      check($sformatf("vec%0d_release", v),
            {s_sel, m_slave_valid, m_slave_ready, dec_ack, dec_err}, 0);
      s_slave_valid = '0;
      s_slave_ready = '0;
    end

    // Stall: bit 0, valid low for 3 cycles with noise on wr, then bit 1.
    exp_q.push_back(5'b10_010);
    @(negedge clk);
    bus_busy       = 1'b1;
    m_master_valid = 1'b1;
    m_wr_bus       = 1'b0;
    @(negedge clk);
    m_master_valid = 1'b0;
    m_wr_bus       = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_quiet", {dec_ack, dec_err, s_sel}, 0);
    @(negedge clk);
    m_master_valid = 1'b1;
    m_wr_bus       = 1'b1;
    @(negedge clk);
    m_master_valid = 1'b0;
    m_wr_bus       = 1'b0;
    check_decode("stall");
    release_bus();

    // Abort: drop bus_busy after the first bit. No pulse may follow.
    @(negedge clk);
    bus_busy       = 1'b1;
    m_master_valid = 1'b1;
    m_wr_bus       = 1'b1;
    @(negedge clk);
    bus_busy       = 1'b0;
    m_master_valid = 1'b0;
    m_wr_bus       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", {dec_ack, dec_err, s_sel}, 0);
    end
    exp_q.push_back(5'b10_001);
    send_id(2'd0);
    check_decode("after_abort");
    release_bus();

    // Return mux to slave 1. Valid stays high so the connection stays active.
    exp_q.push_back(5'b10_010);
    send_id(2'd1);
    check_decode("mux");
    m_master_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat           = 3'(i);
      sv            = 3'($urandom_range(0, 7));
      s_rd_bus      = pat;
      s_slave_valid = sv;
      #1;
      check("mux_rd", m_rd_bus, pat[1]);
      check("mux_valid", m_slave_valid, sv[1]);
      @(negedge clk);
    end
    bus_busy       = 1'b0;
    m_master_valid = 1'b0;
    s_rd_bus       = 3'b111;
    @(negedge clk);
    check("mux_released", m_rd_bus, 1'b0);
    s_rd_bus      = '0;
    s_slave_valid = '0;

    // Asynchronous reset asserted during the dec_ack cycle, between edges.
    exp_q.push_back(5'b10_001);
    send_id(2'd0);
    check_decode("arst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_immediate", {s_sel, dec_ack, dec_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_after", {s_sel, dec_ack, dec_err}, 0);
    exp_q.push_back(5'b10_100);
    send_id(2'd2);
    check_decode("arst_reconnect");
    release_bus();

`ifdef ADDR_DEC_TIMEOUT_EN
    // Idle timeout: 4 quiet CONNECT cycles give dec_err and drop s_sel.
    exp_q.push_back(5'b10_001);
    send_id(2'd0);
    check_decode("tmo");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tmo_wait", {dec_err, s_sel}, 4'b0_001);
    end
    @(negedge clk);
    check("tmo_fire", {dec_ack, dec_err, s_sel}, 5'b01_000);
    @(negedge clk);
    check("tmo_clear", {dec_err, s_sel}, 0);
    release_bus();

    // Release on the same edge as the timeout: the release wins.
    exp_q.push_back(5'b10_001);
    send_id(2'd0);
    check_decode("tmo_rel");
    repeat (3) @(negedge clk);
    bus_busy = 1'b0;
    @(negedge clk);
    check("tmo_rel_edge", {dec_err, s_sel}, 0);
    @(negedge clk);
    check("tmo_rel_after", dec_err, 1'b0);
`else
    // Without the watchdog a quiet connection persists.
    exp_q.push_back(5'b10_001);
    send_id(2'd0);
    check_decode("no_tmo");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_tmo_hold", {dec_err, s_sel}, 4'b0_001);
    end
    release_bus();
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
